// File: rtl/mips_encode.sv
// mips_encode: turns mnemonic-level requests into 32-bit MIPS instruction words.
// One-entry registered output stage; LI is expanded into one or two words.
module mips_encode (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_imm,
    input  logic [25:0] req_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic        err,
    output logic [15:0] inst_count
);

    // Major opcodes
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpAddi    = 6'h08;
    localparam logic [5:0] OpAndi    = 6'h0C;
    localparam logic [5:0] OpOri     = 6'h0D;
    localparam logic [5:0] OpXori    = 6'h0E;
    localparam logic [5:0] OpLui     = 6'h0F;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpLbu     = 6'h24;
    localparam logic [5:0] OpSb      = 6'h28;
    localparam logic [5:0] OpSw      = 6'h2B;

    // SPECIAL funct codes; ADDM uses the otherwise unassigned 6'h2C
    localparam logic [5:0] Op0Jr   = 6'h08;
    localparam logic [5:0] Op0Add  = 6'h20;
    localparam logic [5:0] Op0Sub  = 6'h22;
    localparam logic [5:0] Op0And  = 6'h24;
    localparam logic [5:0] Op0Or   = 6'h25;
    localparam logic [5:0] Op0Xor  = 6'h26;
    localparam logic [5:0] Op0Nor  = 6'h27;
    localparam logic [5:0] Op0Slt  = 6'h2A;
    localparam logic [5:0] Op0Addm = 6'h2C;

    // Request operation select
    localparam logic [4:0] SelAdd  = 5'd0;
    localparam logic [4:0] SelSub  = 5'd1;
    localparam logic [4:0] SelAnd  = 5'd2;
    localparam logic [4:0] SelOr   = 5'd3;
    localparam logic [4:0] SelNor  = 5'd4;
    localparam logic [4:0] SelXor  = 5'd5;
    localparam logic [4:0] SelSlt  = 5'd6;
    localparam logic [4:0] SelJr   = 5'd7;
    localparam logic [4:0] SelAddm = 5'd8;
    localparam logic [4:0] SelAddi = 5'd9;
    localparam logic [4:0] SelAndi = 5'd10;
    localparam logic [4:0] SelOri  = 5'd11;
    localparam logic [4:0] SelXori = 5'd12;
    localparam logic [4:0] SelLui  = 5'd13;
    localparam logic [4:0] SelBeq  = 5'd14;
    localparam logic [4:0] SelBne  = 5'd15;
    localparam logic [4:0] SelJ    = 5'd16;
    localparam logic [4:0] SelLw   = 5'd17;
    localparam logic [4:0] SelLbu  = 5'd18;
    localparam logic [4:0] SelSw   = 5'd19;
    localparam logic [4:0] SelSb   = 5'd20;
    localparam logic [4:0] SelLi   = 5'd21;
    localparam logic [4:0] SelNop  = 5'd22;

    typedef enum logic [0:0] {StIdle, StSecond} state_e;

    state_e      state_q, state_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;
    logic [4:0]  pend_rt_q, pend_rt_d;
    logic [15:0] pend_lo_q, pend_lo_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        enc_two;
    logic        accept;
    logic        drain;
    logic        can_load;

    // Encode the current request into its first (or only) word
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        enc_two   = 1'b0;
        case (req_op)
            SelAdd:  enc_word = {OpSpecial, req_rs, req_rt, req_rd, 5'b0, Op0Add};
            SelSub:  enc_word = {OpSpecial, req_rs, req_rt, req_rd, 5'b0, Op0Sub};
            SelAnd:  enc_word = {OpSpecial, req_rs, req_rt, req_rd, 5'b0, Op0And};
            SelOr:   enc_word = {OpSpecial, req_rs, req_rt, req_rd, 5'b0, Op0Or};
            SelNor:  enc_word = {OpSpecial, req_rs, req_rt, req_rd, 5'b0, Op0Nor};
            SelXor:  enc_word = {OpSpecial, req_rs, req_rt, req_rd, 5'b0, Op0Xor};
            SelSlt:  enc_word = {OpSpecial, req_rs, req_rt, req_rd, 5'b0, Op0Slt};
            SelAddm: enc_word = {OpSpecial, req_rs, req_rt, req_rd, 5'b0, Op0Addm};
            SelJr:   enc_word = {OpSpecial, req_rs, 15'b0, Op0Jr};
            SelAddi: enc_word = {OpAddi, req_rs, req_rt, req_imm[15:0]};
            SelAndi: enc_word = {OpAndi, req_rs, req_rt, req_imm[15:0]};
            SelOri:  enc_word = {OpOri, req_rs, req_rt, req_imm[15:0]};
            SelXori: enc_word = {OpXori, req_rs, req_rt, req_imm[15:0]};
            SelLui:  enc_word = {OpLui, 5'b0, req_rt, req_imm[15:0]};
            SelBeq:  enc_word = {OpBeq, req_rs, req_rt, req_imm[15:0]};
            SelBne:  enc_word = {OpBne, req_rs, req_rt, req_imm[15:0]};
            SelJ:    enc_word = {OpJ, req_target};
            SelLw:   enc_word = {OpLw, req_rs, req_rt, req_imm[15:0]};
            SelLbu:  enc_word = {OpLbu, req_rs, req_rt, req_imm[15:0]};
            SelSw:   enc_word = {OpSw, req_rs, req_rt, req_imm[15:0]};
            SelSb:   enc_word = {OpSb, req_rs, req_rt, req_imm[15:0]};
            SelNop:  enc_word = 32'h0000_0000;
            SelLi: begin
                if (req_imm[31:16] == 16'h0000) begin
                    enc_word = {OpOri, 5'b0, req_rt, req_imm[15:0]};
                end else if (req_imm[15:0] == 16'h0000) begin
                    enc_word = {OpLui, 5'b0, req_rt, req_imm[31:16]};
                end else begin
                    enc_word = {OpLui, 5'b0, req_rt, req_imm[31:16]};
                    enc_two  = 1'b1;
                end
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign can_load  = ~inst_valid_q | inst_ready;
    assign req_ready = (state_q == StIdle) & can_load;
    assign accept    = req_valid & req_ready;
    assign drain     = inst_valid_q & inst_ready;

    // Next-state: FSM, output stage, pending ORI, error pulse and hand-off count
    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q & ~drain;
        inst_d       = inst_q;
        pend_rt_d    = pend_rt_q;
        pend_lo_d    = pend_lo_q;
        err_d        = accept & ~enc_legal;
        count_d      = drain ? count_q + 16'd1 : count_q;
        if (state_q == StSecond) begin
            if (can_load) begin
                inst_d       = {OpOri, pend_rt_q, pend_rt_q, pend_lo_q};
                inst_valid_d = 1'b1;
                state_d      = StIdle;
            end
        end else if (accept && enc_legal) begin
            inst_d       = enc_word;
            inst_valid_d = 1'b1;
            if (enc_two) begin
                state_d   = StSecond;
                pend_rt_d = req_rt;
                pend_lo_d = req_imm[15:0];
            end
        end
    end

    // State registers; reset overrides any same-edge handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0000_0000;
            err_q        <= 1'b0;
            count_q      <= 16'h0000;
            pend_rt_q    <= 5'd0;
            pend_lo_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            err_q        <= err_d;
            count_q      <= count_d;
            pend_rt_q    <= pend_rt_d;
            pend_lo_q    <= pend_lo_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign err        = err_q;
    assign inst_count = count_q;

endmodule

// File: tb/tb_mips_encode.sv
// Directed bench for mips_encode: encodings, LI expansion, backpressure, illegal op,
// counter wrap and reset during a two-word LI.
module tb_mips_encode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = 5'd0;
    logic [4:0]  req_rs = 5'd0;
    logic [4:0]  req_rt = 5'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [31:0] req_imm = 32'h0;
    logic [25:0] req_target = 26'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic        err;
    logic [15:0] inst_count;

    int n_checks = 0;
    int n_fail   = 0;

    mips_encode dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_imm    (req_imm),
        .req_target (req_target),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .err        (err),
        .inst_count (inst_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until accepted; returns just after the accepting edge
    task automatic do_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [25:0] target);
        int k;
        @(negedge clock);
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
        req_imm = imm; req_target = target;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (k == 20) check_val("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    int stalls;

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_val("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check_val("rst_inst", inst, 32'h0);
        check_val("rst_err", {31'b0, err}, 32'd0);
        check_val("rst_count", {16'b0, inst_count}, 32'd0);
        check_val("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Single-word encodings, each visible one cycle after acceptance
        do_req(5'd0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        @(negedge clock);
        check_val("add_valid", {31'b0, inst_valid}, 32'd1);
        check_val("add_word", inst, 32'h0022_1820);
        do_req(5'd9, 5'd4, 5'd5, 5'd0, 32'h0000_FFFF, 26'h0);
        @(negedge clock);
        check_val("addi_word", inst, 32'h2085_FFFF);
        do_req(5'd16, 5'd0, 5'd0, 5'd0, 32'h0, 26'h10);
        @(negedge clock);
        check_val("j_word", inst, 32'h0800_0010);
        @(negedge clock);
        check_val("single_drained", {31'b0, inst_valid}, 32'd0);
        check_val("single_count", {16'b0, inst_count}, 32'd3);

        // LI expansion
        do_req(5'd21, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 26'h0);
        @(negedge clock);
        check_val("li2_lui", inst, 32'h3C08_1234);
        check_val("li2_ready_low", {31'b0, req_ready}, 32'd0);
        @(negedge clock);
        check_val("li2_ori", inst, 32'h3508_5678);
        check_val("li2_ori_valid", {31'b0, inst_valid}, 32'd1);
        check_val("li2_ready_back", {31'b0, req_ready}, 32'd1);
        do_req(5'd21, 5'd0, 5'd8, 5'd0, 32'h0000_00FF, 26'h0);
        @(negedge clock);
        check_val("li_lo_ori", inst, 32'h3408_00FF);
        @(negedge clock);
        check_val("li_lo_single", {31'b0, inst_valid}, 32'd0);
        do_req(5'd21, 5'd0, 5'd8, 5'd0, 32'hABCD_0000, 26'h0);
        @(negedge clock);
        check_val("li_hi_lui", inst, 32'h3C08_ABCD);
        @(negedge clock);
        check_val("li_hi_single", {31'b0, inst_valid}, 32'd0);
        check_val("li_count", {16'b0, inst_count}, 32'd7);

        // Backpressure on an SW word
        inst_ready = 1'b0;
        do_req(5'd19, 5'd29, 5'd31, 5'd0, 32'h0000_0004, 26'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_val("bp_inst", inst, 32'hAFBF_0004);
            check_val("bp_valid", {31'b0, inst_valid}, 32'd1);
            check_val("bp_req_ready", {31'b0, req_ready}, 32'd0);
            check_val("bp_count", {16'b0, inst_count}, 32'd7);
        end
        inst_ready = 1'b1;
        @(negedge clock);
        check_val("bp_release_count", {16'b0, inst_count}, 32'd8);
        check_val("bp_release_valid", {31'b0, inst_valid}, 32'd0);

        // Illegal op: accepted, one-cycle err, no word
        do_req(5'd25, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        @(negedge clock);
        check_val("ill_err", {31'b0, err}, 32'd1);
        check_val("ill_valid", {31'b0, inst_valid}, 32'd0);
        @(negedge clock);
        check_val("ill_err_pulse", {31'b0, err}, 32'd0);
        check_val("ill_count", {16'b0, inst_count}, 32'd8);

        // Reset during the SECOND cycle of a two-word LI
        do_req(5'd21, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 26'h0);
        @(negedge clock);
        check_val("rli_lui", inst, 32'h3C08_1234);
        reset = 1'b1;
        @(negedge clock);
        check_val("rli_valid", {31'b0, inst_valid}, 32'd0);
        check_val("rli_count", {16'b0, inst_count}, 32'd0);
        check_val("rli_req_ready", {31'b0, req_ready}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_val("rli_no_ori", {31'b0, inst_valid}, 32'd0);
        end

        // Back-to-back NOP stream: no stall, count wraps
        stalls = 0;
        req_op = 5'd22;
        req_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (!req_ready) stalls++;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        @(negedge clock);
        check_val("stream_last_valid", {31'b0, inst_valid}, 32'd1);
        check_val("stream_nop_word", inst, 32'h0);
        @(negedge clock);
        check_val("stream_stalls", stalls, 32'd0);
        check_val("stream_wrap_count", {16'b0, inst_count}, 32'd4464);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_encode.md
# mips_encode

Instruction encoder and issue buffer: the transmit end of the instruction-word interface that `mips_decode` consumes. It takes mnemonic-level requests (operation select plus register numbers, immediate, jump target) over a valid/ready handshake and emits well-formed 32-bit MIPS words through a one-entry registered output stage. It also expands the `LI` pseudo-instruction into one or two words. It is used by the instruction-memory loader and by the verification stimulus generators.

## Interface
- Parameters: none. Opcode and funct values come from the shared `OP_*` / `OP0_*` macro definitions.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  **one clock; reset is synchronous and active-high.**
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on any edge where `req_valid & req_ready`.
- `req_op`  in  5  operation select:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLT, 7 JR, 8 ADDM
  - 9 ADDI, 10 ANDI, 11 ORI, 12 XORI, 13 LUI, 14 BEQ, 15 BNE, 16 J
  - 17 LW, 18 LBU, 19 SW, 20 SB, 21 LI (pseudo), 22 NOP
  - 23–31 illegal
- `req_rs`, `req_rt`, `req_rd`  in  5 each  register numbers.
- `req_imm`  in  32  immediate. Bits [15:0] are used except by LI. Branch offsets are word offsets supplied by the caller.
- `req_target`  in  26  J target field.
- `inst_valid`  out  1  `inst` holds a word.
- `inst_ready`  in  1  consumer takes the word on any edge where `inst_valid & inst_ready`.
- `inst`  out  32  encoded instruction.
- `err`  out  1  one-cycle pulse: an illegal `req_op` was accepted.
- `inst_count`  out  16  number of words handed off since reset; wraps modulo 2^16.

## Operation
- **R-type** (ADD..SLT, ADDM): `{6'b0, rs, rt, rd, 5'b0, funct}`.
- **JR**: `{6'b0, rs, 15'b0, OP0_JR}`.
- **I-type** (ADDI/ANDI/ORI/XORI, BEQ/BNE, loads, stores): `{op, rs, rt, imm[15:0]}`.
- **LUI**: `{OP_LUI, 5'b0, rt, imm[15:0]}`.
- **J**: `{OP_J, target}`.
- **NOP**: 32'h0000_0000.
- **LI** (destination `rt`):
  - If `imm[31:16] == 0`: one word, `ORI rt, $0, imm[15:0]`.
  - Else if `imm[15:0] == 0`: one word, `LUI rt, imm[31:16]`.
  - Else: two words, `LUI rt, imm[31:16]` then `ORI rt, rt, imm[15:0]`.
- **Illegal op**: the handshake completes and no word is emitted. `err` is high for exactly the cycle after acceptance.
- **FSM**:
  - IDLE → SECOND on acceptance of a two-word LI. The low half and `rt` are captured in a pending register.
  - SECOND → IDLE on the edge where the ORI word is loaded into the output stage.
- **Output stage**: one register.
  - Loaded with a new word when it is empty or being drained on the same edge.
  - `inst` is held stable while `inst_valid & ~inst_ready`.
- `req_ready` = (state == IDLE) & (~inst_valid | inst_ready). It is combinational and has no dependence on `req_valid`.
- `inst_count` increments on each edge with `inst_valid & inst_ready` and wraps from 16'hFFFF to 0.

## Timing
- **Reset values**: `inst_valid` = 0, `inst` = 0, `err` = 0, `inst_count` = 0, FSM = IDLE. `req_ready` is therefore 1 in the first cycle after reset.
- **Latency**: a request accepted at edge N has its word visible with `inst_valid = 1` in cycle N+1.
- **Throughput**: with `inst_ready` held high, one single-word request per cycle.
- **Two-word LI**:
  - LUI is visible in cycle N+1 and ORI in cycle N+2 (if LUI is taken at edge N+1).
  - `req_ready` is 0 throughout SECOND.
- **Backpressure**: with `inst_ready` = 0 and `inst_valid` = 1, `req_ready` = 0. Pending state and `inst` do not change.
- **Simultaneous drain and accept**: on the same edge, the output register takes the new word, `inst_valid` stays 1, and the count increments.
- **Illegal op with a word already valid**: the word remains valid and `err` still pulses. No bubble word is inserted.
- **Reset asserted mid-LI or under backpressure**: the pending ORI and the output word are discarded, and the count clears. Reset wins over any same-edge handshake.

## Test plan
- **Single-word encodings**: with `inst_ready` = 1, send:
  - ADD rs=1 rt=2 rd=3 → 32'h0022_1820
  - ADDI rs=4 rt=5 imm=16'hFFFF → 32'h2085_FFFF
  - J target=26'h10 → 32'h0800_0010
  - Each word appears one cycle after acceptance.
- **LI expansion**:
  - rt=8, imm=32'h1234_5678 → 32'h3C08_1234 then 32'h3508_5678 on consecutive cycles, with `req_ready` low for one cycle.
  - imm=32'h0000_00FF → only 32'h3408_00FF.
  - imm=32'hABCD_0000 → only 32'h3C08_ABCD.
- **Backpressure**: hold `inst_ready` = 0 for 5 cycles after an SW request (rs=29 rt=31 imm=4 → 32'hAFBF_0004). Required: `inst` stable, `req_ready` = 0, `inst_count` unchanged; release → count +1.
- **Illegal op**: `req_op` = 25 → accepted, `err` = 1 for one cycle, `inst_valid` stays 0, count unchanged.
- **Back-to-back stream**: 70000 NOPs with `inst_ready` = 1 every cycle. Required: no stall, and `inst_count` wraps to 70000 − 65536 = 4464.
- **Reset mid-LI**: assert `reset` in the SECOND cycle of a 32'h1234_5678 LI. Required: next cycle `inst_valid` = 0, `inst_count` = 0, `req_ready` = 1, and no ORI word is ever emitted.
